// File: rtl/sound_pkg.sv
// Shared constants for the tone generators and the tone meter: the system
// clock, note frequencies and the gate-window arithmetic.
package sound_pkg;

    localparam int unsigned CLK_FREQ = 50_000_000;

    localparam int unsigned NOTE_C4 = 262;
    localparam int unsigned NOTE_E4 = 330;
    localparam int unsigned NOTE_G4 = 392;
    localparam int unsigned NOTE_A4 = 440;
    localparam int unsigned NOTE_C5 = 523;
    localparam int unsigned NOTE_E5 = 659;

    localparam int          FREQ_W   = 17;
    localparam int unsigned FREQ_MAX = (1 << FREQ_W) - 1;

    // gate_ms must divide 1000, so both results are exact integers.
    function automatic int unsigned gate_cycles(input int unsigned clk_freq,
                                                input int unsigned gate_ms);
        return clk_freq / 1000 * gate_ms;
    endfunction

    function automatic int unsigned gate_scale(input int unsigned gate_ms);
        return 1000 / gate_ms;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer for an asynchronous level input with a one-cycle
// rising-edge pulse; also used for the button inputs.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic [2:0] sync_q;

    // NOTE: sequential state is written with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tone_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a fixed
// gate window, scales the count to Hz and flags a match against TARGET+/-TOL.
module tone_meter #(
    parameter int unsigned CLK_FREQ = sound_pkg::CLK_FREQ,
    parameter int unsigned GATE_MS  = 100,
    parameter int unsigned TARGET   = sound_pkg::NOTE_A4,
    parameter int unsigned TOL      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        sig_in,
    output logic [16:0] freq_hz,
    output logic        valid,
    output logic        overflow,
    output logic        match
);

    import sound_pkg::*;

    localparam int unsigned GATE_CYCLES = gate_cycles(CLK_FREQ, GATE_MS);
    localparam int unsigned SCALE       = gate_scale(GATE_MS);
    localparam int unsigned LO          = (TARGET > TOL) ? TARGET - TOL : 0;
    localparam int unsigned HI          = TARGET + TOL;
    localparam int          GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              rise;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [FREQ_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [FREQ_W-1:0] edge_final;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic              match_q, match_d;
    logic [31:0]       prod;
    logic              prod_ovf;

    sync_edge_det u_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (sig_in),
        .rise_o (rise)
    );

    // edge_final includes a rise arriving in the current cycle, so a rise in the
    // last window cycle is counted in the window it belongs to.
    always_comb begin
        edge_final = edge_cnt_q;
        if (rise && (edge_cnt_q != FREQ_W'(FREQ_MAX))) begin
            edge_final = edge_cnt_q + 1'b1;
        end
        prod     = 32'(edge_final) * SCALE;
        prod_ovf = (prod > FREQ_MAX);
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        valid_d    = 1'b0;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        match_d    = match_q;
        if (en) begin
            if (gate_cnt_q == GATE_LAST) begin
                valid_d    = 1'b1;
                overflow_d = prod_ovf;
                freq_d     = prod_ovf ? '1 : prod[FREQ_W-1:0];
                match_d    = !prod_ovf && (prod >= LO) && (prod <= HI);
            end else begin
                gate_cnt_d = gate_cnt_q + 1'b1;
                edge_cnt_d = edge_final;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            match_q    <= match_d;
        end
    end

    assign freq_hz  = freq_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign match    = match_q;

endmodule

// File: tb/tb_tone_meter.sv
// Self-checking bench for tone_meter: table-driven windows with a scoreboard,
// an overflow instance, en drop/re-enable and async reset corner cases.
module tb_tone_meter;

    localparam int GATE = 1000;

    typedef struct {
        int period;
        int pulses;
        int lo;
        int hi;
        bit ovf;
        bit match;
    } vec_t;

    typedef struct {
        int lo;
        int hi;
        bit ovf;
        bit match;
    } exp_t;

    exp_t sb[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en1 = 1'b0;
    logic        en2 = 1'b0;
    logic        sig_man = 1'b0;
    logic        sig_per = 1'b0;
    int          period = 0;
    logic        sig_in;
    logic [16:0] f1, f2;
    logic        v1, v2, o1, o2, m1, m2;
    int          tests = 0;
    int          fails = 0;

    assign sig_in = (period == 0) ? sig_man : sig_per;

    always #5 clk = ~clk;

    tone_meter #(.CLK_FREQ(100_000), .GATE_MS(10), .TARGET(5000), .TOL(100)) dut1 (
        .clk(clk), .reset(reset), .en(en1), .sig_in(sig_in),
        .freq_hz(f1), .valid(v1), .overflow(o1), .match(m1)
    );

    tone_meter #(.CLK_FREQ(1_000_000), .GATE_MS(1), .TARGET(5000), .TOL(100)) dut2 (
        .clk(clk), .reset(reset), .en(en2), .sig_in(sig_in),
        .freq_hz(f2), .valid(v2), .overflow(o2), .match(m2)
    );

    // Periodic square-wave source, changing on the falling clock edge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (period == 0) begin
                ph      = 0;
                sig_per = 1'b0;
            end else begin
                sig_per = (ph < period / 2);
                ph      = (ph + 1 >= period) ? 0 : ph + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input logic [31:0] act, input int lo, input int hi);
        tests++;
        if ($isunknown(act) || act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pop_check(input int which);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 1);
            return;
        end
        e = sb.pop_front();
        if (which == 0) begin
            check_rng("freq_hz", 32'(f1), e.lo, e.hi);
            check("overflow", 32'(o1), 32'(e.ovf));
            check("match", 32'(m1), 32'(e.match));
        end else begin
            check_rng("freq_hz2", 32'(f2), e.lo, e.hi);
            check("overflow2", 32'(o2), 32'(e.ovf));
            check("match2", 32'(m2), 32'(e.match));
        end
    endtask

    // Waits for a valid pulse, sampling on falling edges; timeout is a failure.
    task automatic wait_valid(input int which, input int budget, output int waited, output bit found);
        waited = 0;
        found  = 1'b0;
        while (!found && waited < budget) begin
            @(negedge clk);
            waited++;
            found = (which == 0) ? v1 : v2;
        end
        if (!found) check("valid_timeout", 0, 1);
    endtask

    function automatic bit pat(input int c);
        return (c >= 100 && c < 104) || (c >= 200 && c < 204) ||
               (c >= 300 && c < 304) || (c >= 997);
    endfunction

    initial begin
        vec_t vecs[8];
        int   w;
        bit   found;
        int   bad;

        vecs[0] = '{20, 0, 5000, 5000, 1'b0, 1'b1};
        vecs[1] = '{16, 0, 6200, 6300, 1'b0, 1'b0};
        vecs[2] = '{19, 0, 5200, 5300, 1'b0, 1'b0};
        vecs[3] = '{0,  0, 0,    0,    1'b0, 1'b0};
        vecs[4] = '{0, 49, 4900, 4900, 1'b0, 1'b1};
        vecs[5] = '{0, 51, 5100, 5100, 1'b0, 1'b1};
        vecs[6] = '{0, 52, 5200, 5200, 1'b0, 1'b0};
        vecs[7] = '{0, 48, 4800, 4800, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_freq", 32'(f1), 0);
        check("reset_valid", 32'(v1), 0);
        check("reset_ovf", 32'(o1), 0);
        check("reset_match", 32'(m1), 0);
        reset = 1'b0;
        en1   = 1'b1;

        for (int i = 0; i < 8; i++) begin
            period  = vecs[i].period;
            sig_man = 1'b0;
            wait_valid(0, 2 * GATE + 10, w, found);
            if (!found) continue;
            for (int p = 0; p < vecs[i].pulses; p++) begin
                sig_man = 1'b1;
                repeat (4) @(negedge clk);
                sig_man = 1'b0;
                repeat (4) @(negedge clk);
            end
            sb.push_back('{vecs[i].lo, vecs[i].hi, vecs[i].ovf, vecs[i].match});
            wait_valid(0, GATE + 5, w, found);
            if (!found) begin
                void'(sb.pop_front());
                continue;
            end
            check("window_interval", 32'(w + vecs[i].pulses * 8), GATE);
            pop_check(0);
            @(negedge clk);
            check("valid_one_cycle", 32'(v1), 0);
        end

        // Overflow: 250 edges per 1 ms window on the second instance.
        period = 4;
        en2    = 1'b1;
        wait_valid(1, GATE + 10, w, found);
        check("dut2_first_latency", 32'(w), GATE);
        sb.push_back('{131071, 131071, 1'b1, 1'b0});
        wait_valid(1, GATE + 5, w, found);
        if (found) pop_check(1);
        else void'(sb.pop_front());
        en2 = 1'b0;

        // en dropped mid-window, then re-enabled.
        period = 20;
        wait_valid(0, 2 * GATE + 10, w, found);
        sb.push_back('{5000, 5000, 1'b0, 1'b1});
        wait_valid(0, GATE + 5, w, found);
        if (found) pop_check(0);
        else void'(sb.pop_front());
        bad = 0;
        repeat (500) @(negedge clk) if (v1) bad++;
        en1 = 1'b0;
        repeat (200) @(negedge clk) if (v1 || f1 != 17'd5000) bad++;
        en1   = 1'b1;
        w     = 0;
        found = 1'b0;
        sb.push_back('{5000, 5000, 1'b0, 1'b1});
        for (int c = 1; c <= GATE + 5 && !found; c++) begin
            @(negedge clk);
            if (v1) begin
                found = 1'b1;
                w     = c;
            end else if (f1 != 17'd5000) begin
                bad++;
            end
        end
        check("en_drop_spurious", 32'(bad), 0);
        check("reenable_latency", 32'(w), GATE);
        if (found) pop_check(0);
        else void'(sb.pop_front());

        // Asynchronous reset mid-window, then a rise on the last window cycle.
        check("pre_reset_freq", 32'(f1), 5000);
        repeat (300) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_freq", 32'(f1), 0);
        check("async_reset_match", 32'(m1), 0);
        check("async_reset_valid", 32'(v1), 0);
        period  = 0;
        sig_man = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad   = 0;
        for (int c = 0; c <= GATE; c++) begin
            if (c > 0) @(negedge clk);
            sig_man = pat(c);
            if (c < GATE && v1) bad++;
        end
        check("reset_early_valid", 32'(bad), 0);
        check("post_reset_valid", 32'(v1), 1);
        sb.push_back('{400, 400, 1'b0, 1'b0});
        pop_check(0);
        sb.push_back('{0, 0, 1'b0, 1'b0});
        wait_valid(0, GATE + 5, w, found);
        check("next_window_interval", 32'(w), GATE);
        if (found) pop_check(0);
        else void'(sb.pop_front());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/tone_meter.md
Name: tone_meter

Overview:
- Measures the frequency of an incoming square wave, such as a game audio tone or an external test signal.
- Counts rising edges over a fixed gate window and reports the result scaled to Hz.
- Flags whether the measured frequency lies within a tolerance band around a target note.
- It is the receive side of the team's tone generators and is used for self-test and for tone-triggered game events.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- GATE_MS, 100: gate window length in ms. Must divide 1000 exactly.
- TARGET, 440: target tone in Hz, used for `match`.
- TOL, 10: match tolerance in Hz, applied as ± around TARGET.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  measurement enable.
- sig_in  input  1  asynchronous square-wave input.
- freq_hz  output  17  last measured frequency in Hz, saturating.
- valid  output  1  one-cycle pulse when freq_hz/overflow/match update.
- overflow  output  1  last window exceeded the 17-bit range.
- match  output  1  last measurement within [TARGET-TOL, TARGET+TOL].

Behaviour:
- Derived constants:
  - GATE_CYCLES = CLK_FREQ/1000*GATE_MS.
  - SCALE = 1000/GATE_MS.
  - LO = max(TARGET-TOL, 0).
  - HI = TARGET+TOL.
- Synchronizer and edge detect:
  - sig_in passes through 2 flops, then a third flop for edge detection.
  - rise = s2 & ~s3.
  - Latency from sig_in rising to rise asserted is 2–3 clk.
- Gate counter:
  - gate_cnt runs 0..GATE_CYCLES-1 while en=1, then wraps to 0.
  - The last window cycle is the cycle with gate_cnt == GATE_CYCLES-1.
- Edge counter:
  - edge_cnt increments on rise and saturates at all-ones (17 bits).
  - A rise in the last window cycle counts in the ending window.
  - edge_cnt is cleared to 0 at the clock edge that ends the window.
- Result latch, at the clock edge ending the last window cycle:
  - prod = final_edge_cnt*SCALE, computed wide enough not to wrap.
  - overflow = (prod > 131071).
  - freq_hz = overflow ? 131071 : prod.
  - match = !overflow && LO <= prod <= HI.
  - valid = 1 for exactly the following cycle, then 0.
  - Outputs other than valid hold until the next window ends.
- en=0:
  - gate_cnt and edge_cnt held at 0; valid=0.
  - freq_hz/overflow/match hold their last values.
  - The synchronizer keeps running.
- en 0→1: a fresh window starts with gate_cnt=0. The first valid arrives GATE_CYCLES cycles after en is first sampled high.
- en dropped mid-window: the partial window is discarded and produces no valid.
- Reset (asynchronous, any time):
  - All flops, including the synchronizer, go to 0.
  - freq_hz=0, valid=0, overflow=0, match=0.
  - After release, the first window starts on the first cycle with en=1.
- No input edges in a window: freq_hz=0, match = (LO==0), valid pulses normally.
- Maximum measurable input is about CLK_FREQ/4 due to the synchronizer. Faster inputs under-count; this is not flagged.

Decomposition:
- Shared package (sound_pkg):
  - CLK_FREQ constant.
  - Note frequency constants (e.g. NOTE_A4=440, NOTE_C5=523), also used by the tone generators.
  - A function computing GATE_CYCLES/SCALE.
- One sub-module, sync_edge_det:
  - 3-flop synchronizer plus rise-pulse output.
  - Async active-high reset, clock clk.
  - Reusable for the button inputs.

Test Plan:
Bench parameters: CLK_FREQ=100000, GATE_MS=10, so GATE_CYCLES=1000 and SCALE=100; TARGET=5000, TOL=100.
1. en=1, sig_in period 20 clk (5000 Hz) → every 1000 cycles valid pulses one cycle; freq_hz=5000, match=1, overflow=0.
2. sig_in period 16 clk (6250 Hz, 62 or 63 edges per window) → freq_hz ∈ {6200, 6300}, match=0.
3. sig_in held at 0 → freq_hz=0, match=0, valid still pulses every 1000 cycles.
4. Parameter GATE_MS=1 (SCALE=1000), sig_in period 4 clk (250 edges) → prod=250000 > 131071, so freq_hz=131071, overflow=1, match=0.
5. en dropped at cycle 500 of a window, re-raised at 700 → no valid at the old boundary; next valid exactly 1000 cycles after re-enable; freq_hz unchanged in between.
6. reset asserted mid-window with freq_hz=5000 → all outputs 0 immediately (async); after release, first valid arrives after 1000 cycles with the correct count. Rise placed exactly on the last window cycle → counted in that window, not the next.
